// File: rtl/digit_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM states,
// digit bundle widths and the blanked-enable pattern.
package digit_pkg;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_G_IN  = 2'd1,
    ST_OVL   = 2'd2,
    ST_G_OUT = 2'd3
  } state_e;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int BUS_W      = NUM_DIGITS * DIGIT_W;

  localparam logic [NUM_DIGITS-1:0] ENA_BLANK = 4'b0000;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that stops at zero; zero_o flags the terminal value.
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/digit_arbiter.sv
// Shares the 4-digit display bundle between the CPU GPIO path and a hardware
// overlay requester, with blank guards on handover, hold, timeout and blink.
module digit_arbiter
  import digit_pkg::*;
#(
  parameter int GUARD_CYCLES = 1000,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int MAX_CYCLES   = 500_000_000,
  parameter int BLINK_DIV    = 12_500_000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [BUS_W-1:0] cpu_dig,
  input  logic [3:0]       cpu_dot,
  input  logic [3:0]       cpu_ena,
  input  logic [3:0]       cpu_crt,
  input  logic             cpu_lock,
  input  logic             ov_req,
  input  logic [BUS_W-1:0] ov_dig,
  input  logic [3:0]       ov_dot,
  input  logic [3:0]       ov_ena,
  input  logic             ov_blink,
  output logic             ov_gnt,
  output logic             ov_done,
  output logic             ov_timeout,
  output logic             owner,
  output logic [3:0]       DIG0,
  output logic [3:0]       DIG1,
  output logic [3:0]       DIG2,
  output logic [3:0]       DIG3,
  output logic [3:0]       DIG_DOT,
  output logic [3:0]       DIG_ENA,
  output logic [3:0]       DIG_CRT
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int MW = $clog2(MAX_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  // Counters load N-1 so that a zero flag marks the last cycle of an N-cycle interval.
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES - 1);
  localparam logic [MW-1:0] MAX_LD   = MW'(MAX_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_DIV - 1);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic             rearm_q, rearm_d;
  logic             gnt_q, gnt_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             owner_q, owner_d;
  logic [BUS_W-1:0] dig_q, dig_d;
  logic [3:0]       dot_q, dot_d;
  logic [3:0]       ena_q, ena_d;
  logic [3:0]       crt_q;

  logic guard_load, guard_en, guard_zero;
  logic ovl_load, ovl_en, hold_zero, tmo_zero;
  logic blink_load, blink_en, blink_zero;

  down_counter #(.W(GW)) u_guard (
    .clk(clk), .rst(RST), .load_i(guard_load), .en_i(guard_en),
    .load_val_i(GUARD_LD), .zero_o(guard_zero)
  );

  down_counter #(.W(HW)) u_hold (
    .clk(clk), .rst(RST), .load_i(ovl_load), .en_i(ovl_en),
    .load_val_i(HOLD_LD), .zero_o(hold_zero)
  );

  down_counter #(.W(MW)) u_timeout (
    .clk(clk), .rst(RST), .load_i(ovl_load), .en_i(ovl_en),
    .load_val_i(MAX_LD), .zero_o(tmo_zero)
  );

  down_counter #(.W(BW)) u_blink (
    .clk(clk), .rst(RST), .load_i(blink_load), .en_i(blink_en),
    .load_val_i(BLINK_LD), .zero_o(blink_zero)
  );

  // Outputs are computed for the state being entered, so they appear with the state.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rearm_d    = ov_req ? rearm_q : 1'b0;
    gnt_d      = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
    owner_d    = owner_q;
    dig_d      = dig_q;
    dot_d      = dot_q;
    ena_d      = ENA_BLANK;
    guard_load = 1'b0;
    guard_en   = 1'b0;
    ovl_load   = 1'b0;
    ovl_en     = 1'b0;
    blink_load = 1'b0;
    blink_en   = 1'b0;

    case (state_q)
      ST_CPU: begin
        owner_d = 1'b0;
        if (ov_req && !cpu_lock && !rearm_q) begin
          state_d    = ST_G_IN;
          guard_load = 1'b1;
        end else begin
          dig_d = cpu_dig;
          dot_d = cpu_dot;
          ena_d = cpu_ena;
        end
      end

      ST_G_IN: begin
        if (!ov_req) begin
          state_d    = ST_G_OUT;
          guard_load = 1'b1;
        end else if (guard_zero) begin
          state_d    = ST_OVL;
          ovl_load   = 1'b1;
          blink_load = 1'b1;
          phase_d    = 1'b1;
          gnt_d      = 1'b1;
          owner_d    = 1'b1;
          dig_d      = ov_dig;
          dot_d      = ov_dot;
          ena_d      = ov_ena;
        end else begin
          guard_en = 1'b1;
        end
      end

      ST_OVL: begin
        if (tmo_zero) begin
          state_d    = ST_G_OUT;
          guard_load = 1'b1;
          tmo_d      = 1'b1;
          if (ov_req) rearm_d = 1'b1;
        end else if (hold_zero && !ov_req) begin
          state_d    = ST_G_OUT;
          guard_load = 1'b1;
          done_d     = 1'b1;
        end else begin
          gnt_d  = 1'b1;
          ovl_en = 1'b1;
          dig_d  = ov_dig;
          dot_d  = ov_dot;
          if (blink_zero) begin
            phase_d    = !phase_q;
            blink_load = 1'b1;
          end else begin
            blink_en = 1'b1;
          end
          ena_d = (ov_blink && !phase_d) ? ENA_BLANK : ov_ena;
        end
      end

      ST_G_OUT: begin
        if (guard_zero) begin
          state_d = ST_CPU;
          owner_d = 1'b0;
          dig_d   = cpu_dig;
          dot_d   = cpu_dot;
          ena_d   = cpu_ena;
        end else begin
          guard_en = 1'b1;
        end
      end

      default: state_d = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_CPU;
      phase_q <= 1'b0;
      rearm_q <= 1'b0;
      gnt_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      owner_q <= 1'b0;
      dig_q   <= '0;
      dot_q   <= '0;
      ena_q   <= ENA_BLANK;
      crt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rearm_q <= rearm_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      owner_q <= owner_d;
      dig_q   <= dig_d;
      dot_q   <= dot_d;
      ena_q   <= ena_d;
      crt_q   <= cpu_crt;
    end
  end

  assign ov_gnt     = gnt_q;
  assign ov_done    = done_q;
  assign ov_timeout = tmo_q;
  assign owner      = owner_q;
  assign DIG0       = dig_q[3:0];
  assign DIG1       = dig_q[7:4];
  assign DIG2       = dig_q[11:8];
  assign DIG3       = dig_q[15:12];
  assign DIG_DOT    = dot_q;
  assign DIG_ENA    = ena_q;
  assign DIG_CRT    = crt_q;

endmodule

// File: tb/tb_digit_arbiter.sv
// Directed bench for digit_arbiter: expected output snapshots go through a
// scoreboard queue and are compared one cycle after the stimulus edge.
module tb_digit_arbiter;

  localparam int G = 4;
  localparam int H = 10;
  localparam int M = 30;
  localparam int B = 3;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] cpu_dig = 16'h1234;
  logic [3:0]  cpu_dot = 4'h5;
  logic [3:0]  cpu_ena = 4'hF;
  logic [3:0]  cpu_crt = 4'h3;
  logic        cpu_lock = 1'b0;
  logic        ov_req = 1'b0;
  logic [15:0] ov_dig = 16'hABCD;
  logic [3:0]  ov_dot = 4'hA;
  logic [3:0]  ov_ena = 4'hF;
  logic        ov_blink = 1'b0;
  logic        ov_gnt, ov_done, ov_timeout, owner;
  logic [3:0]  DIG0, DIG1, DIG2, DIG3, DIG_DOT, DIG_ENA, DIG_CRT;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  digit_arbiter #(
    .GUARD_CYCLES(G), .HOLD_CYCLES(H), .MAX_CYCLES(M), .BLINK_DIV(B)
  ) dut (
    .clk(clk), .RST(RST),
    .cpu_dig(cpu_dig), .cpu_dot(cpu_dot), .cpu_ena(cpu_ena), .cpu_crt(cpu_crt),
    .cpu_lock(cpu_lock),
    .ov_req(ov_req), .ov_dig(ov_dig), .ov_dot(ov_dot), .ov_ena(ov_ena),
    .ov_blink(ov_blink),
    .ov_gnt(ov_gnt), .ov_done(ov_done), .ov_timeout(ov_timeout), .owner(owner),
    .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
    .DIG_DOT(DIG_DOT), .DIG_ENA(DIG_ENA), .DIG_CRT(DIG_CRT)
  );

  wire [31:0] obs = {DIG3, DIG2, DIG1, DIG0, DIG_DOT, DIG_ENA, DIG_CRT,
                     ov_gnt, ov_done, ov_timeout, owner};

  function automatic logic [31:0] mk(input logic [15:0] d, input logic [3:0] dt,
                                     input logic [3:0] en, input logic [3:0] crt,
                                     input logic gnt, input logic done,
                                     input logic tmo, input logic own);
    return {d, dt, en, crt, gnt, done, tmo, own};
  endfunction

  function automatic logic [31:0] exp_cpu();
    return mk(cpu_dig, cpu_dot, cpu_ena, cpu_crt, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] exp_blank(input logic own, input logic [15:0] d,
                                            input logic [3:0] dt);
    return mk(d, dt, 4'h0, cpu_crt, 1'b0, 1'b0, 1'b0, own);
  endfunction

  function automatic logic [31:0] exp_ovl(input logic [3:0] en);
    return mk(ov_dig, ov_dot, en, cpu_crt, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string tag);
    logic [31:0] e;
    e = sb_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [31:0] e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    chk(tag);
  endtask

  initial begin
    // Reset held: everything zero.
    cyc("reset_0", 32'h0);
    cyc("reset_1", 32'h0);
    RST = 1'b0;
    cyc("cpu_after_reset", exp_cpu());
    cpu_crt = 4'h9;
    cyc("cpu_crt_track", exp_cpu());

    // Request withdrawn inside the entry guard: abort via exit guard, no pulse.
    ov_req = 1'b1;
    cyc("gin_abort_a", exp_blank(1'b0, 16'h1234, 4'h5));
    cyc("gin_abort_b", exp_blank(1'b0, 16'h1234, 4'h5));
    ov_req = 1'b0;
    for (int i = 0; i < G; i++) cyc("gout_abort", exp_blank(1'b0, 16'h1234, 4'h5));
    cyc("cpu_after_abort", exp_cpu());

    // Normal overlay: guard, 10 cycles of ABCD, done pulse, guard, CPU.
    ov_req = 1'b1;
    for (int i = 0; i < G; i++) cyc("gin_normal", exp_blank(1'b0, 16'h1234, 4'h5));
    for (int i = 0; i < H; i++) begin
      if (i == 2) ov_req = 1'b0;
      cyc("ovl_hold", exp_ovl(4'hF));
    end
    cyc("ov_done_pulse", mk(16'hABCD, 4'hA, 4'h0, cpu_crt, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int i = 1; i < G; i++) cyc("gout_normal", exp_blank(1'b1, 16'hABCD, 4'hA));
    cyc("cpu_after_done", exp_cpu());

    // Held request: timeout after 30 granted cycles, then no re-grant until re-armed.
    ov_req = 1'b1;
    for (int i = 0; i < G; i++) cyc("gin_tmo", exp_blank(1'b0, 16'h1234, 4'h5));
    for (int i = 0; i < M; i++) begin
      if (i == 10) ov_dig = 16'h5678;
      cyc("ovl_tmo", exp_ovl(4'hF));
    end
    cyc("ov_timeout_pulse", mk(16'h5678, 4'hA, 4'h0, cpu_crt, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 1; i < G; i++) cyc("gout_tmo", exp_blank(1'b1, 16'h5678, 4'hA));
    for (int i = 0; i < 5; i++) cyc("no_regrant", exp_cpu());
    ov_req = 1'b0;
    cyc("rearm_clear", exp_cpu());
    ov_req = 1'b1;
    cyc("regrant_gin", exp_blank(1'b0, 16'h1234, 4'h5));
    ov_req = 1'b0;
    for (int i = 0; i < G; i++) cyc("regrant_abort", exp_blank(1'b0, 16'h1234, 4'h5));
    cyc("cpu_after_rearm", exp_cpu());
    ov_dig = 16'hABCD;

    // CPU lock rising with the request: deferred until the lock drops.
    cpu_lock = 1'b1;
    ov_req   = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lock_defer", exp_cpu());
    cpu_lock = 1'b0;
    ov_blink = 1'b1;
    for (int i = 0; i < G; i++) cyc("gin_unlock", exp_blank(1'b0, 16'h1234, 4'h5));

    // Blink: F,F,F,0,0,0 repeating, CRT tracking a changing CPU field.
    for (int i = 0; i < H; i++) begin
      cpu_crt = 4'(i + 1);
      if (i == 1) cpu_lock = 1'b1;
      if (i == 2) ov_req = 1'b0;
      cyc("ovl_blink", exp_ovl(((i / B) % 2 == 0) ? 4'hF : 4'h0));
    end
    cpu_lock = 1'b0;
    cyc("blink_done", mk(16'hABCD, 4'hA, 4'h0, cpu_crt, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int i = 1; i < G; i++) cyc("gout_blink", exp_blank(1'b1, 16'hABCD, 4'hA));
    ov_blink = 1'b0;
    cyc("cpu_after_blink", exp_cpu());

    // Reset five cycles into a grant: immediate zeros, no pulses.
    ov_req = 1'b1;
    for (int i = 0; i < G; i++) cyc("gin_rst", exp_blank(1'b0, 16'h1234, 4'h5));
    for (int i = 0; i < 5; i++) cyc("ovl_rst", exp_ovl(4'hF));
    RST = 1'b1;
    sb_q.push_back(32'h0);
    #1;
    chk("reset_mid_ovl");
    cyc("reset_hold_0", 32'h0);
    cyc("reset_hold_1", 32'h0);
    ov_req = 1'b0;
    RST    = 1'b0;
    cyc("cpu_after_mid_reset", exp_cpu());
    cyc("cpu_final", exp_cpu());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
